// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: req/ack instruction fetch with timeout NOP substitution.
// Define PREFETCH_EN to add a one-entry next-word prefetch buffer (PF state).
module inst_fetch_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int TIMEOUT_CYC = 15,
  parameter logic [DATA_W-1:0] NOP_INST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       pc,
  input  logic              fetch_req,
  input  logic              flush,
  output logic              busy,
  output logic [DATA_W-1:0] inst,
  output logic              inst_valid,
  output logic              fetch_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CLAST = CW'(TIMEOUT_CYC - 1);
  typedef enum logic [1:0] {IDLE, REQ, RESP, PF} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic drop;
  logic tmo;
  logic pend_v;
  // the watchdog only fires on a cycle with no ack, so a late ack always wins
  assign tmo = !mem_ack && cnt == CLAST;
  assign busy = state == REQ || state == RESP || pend_v;
`ifdef PREFETCH_EN
  logic [15:0] fetch_pc, pend_pc, pf_addr, nxt, req_pc;
  logic [DATA_W-1:0] pf_data;
  logic pf_valid, req_v;
  assign nxt = fetch_pc + 16'd1;
  // a request arriving on the very edge the prefetch ends is served as if pending
  assign req_v = pend_v || (fetch_req && !flush);
  assign req_pc = pend_v ? pend_pc : pc;
`else
  assign pend_v = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      mem_rd <= 1'b0;
      mem_addr <= '0;
      inst <= '0;
      inst_valid <= 1'b0;
      fetch_err <= 1'b0;
      cnt <= '0;
      drop <= 1'b0;
`ifdef PREFETCH_EN
      fetch_pc <= '0;
      pend_v <= 1'b0;
      pend_pc <= '0;
      pf_addr <= '0;
      pf_data <= '0;
      pf_valid <= 1'b0;
`endif
    end else begin
      inst_valid <= 1'b0;
      fetch_err <= 1'b0;
      case (state)
        IDLE: if (fetch_req && !flush) begin
`ifdef PREFETCH_EN
          fetch_pc <= pc;
          if (pf_valid && pc == pf_addr) begin
            inst <= pf_data;
            inst_valid <= 1'b1;
            state <= RESP;
          end else
`endif
          begin
            mem_addr <= pc[ADDR_W-1:0];
            mem_rd <= 1'b1;
            cnt <= '0;
            drop <= 1'b0;
            state <= REQ;
          end
        end
        REQ: if (mem_ack || tmo) begin
          mem_rd <= 1'b0;
          state <= (drop || flush) ? IDLE : RESP;
          if (!(drop || flush)) begin
            inst <= mem_ack ? mem_rdata : NOP_INST;
            inst_valid <= 1'b1;
            fetch_err <= !mem_ack;
          end
        end else begin
          cnt <= cnt + 1'b1;
          drop <= drop || flush;
        end
`ifdef PREFETCH_EN
        RESP: if (flush) state <= IDLE;
        else begin
          mem_addr <= nxt[ADDR_W-1:0];
          mem_rd <= 1'b1;
          pf_addr <= nxt;
          pf_valid <= 1'b0;
          cnt <= '0;
          drop <= 1'b0;
          state <= PF;
        end
        PF: if (mem_ack || tmo) begin
          mem_rd <= 1'b0;
          pf_data <= mem_rdata;
          pf_valid <= mem_ack && !drop && !flush;
          pend_v <= 1'b0;
          state <= IDLE;
          if (req_v && !flush) begin
            fetch_pc <= req_pc;
            if (mem_ack && !drop && req_pc == pf_addr) begin
              inst <= mem_rdata;
              inst_valid <= 1'b1;
              state <= RESP;
            end else begin
              mem_addr <= req_pc[ADDR_W-1:0];
              mem_rd <= 1'b1;
              cnt <= '0;
              drop <= 1'b0;
              state <= REQ;
            end
          end
        end else begin
          cnt <= cnt + 1'b1;
          drop <= drop || flush;
          if (!pend_v && fetch_req && !flush) begin
            pend_v <= 1'b1;
            pend_pc <= pc;
          end
        end
`else
        RESP: state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
`ifdef PREFETCH_EN
      if (flush) begin
        pend_v <= 1'b0;
        pf_valid <= 1'b0;
      end
`endif
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed checks of inst_fetch_unit in its default (no prefetch) build.
module tb_inst_fetch_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] pc = '0, inst, mem_addr, mem_rdata = '0;
  logic fetch_req = 1'b0, flush = 1'b0, mem_ack = 1'b0;
  logic busy, inst_valid, fetch_err, mem_rd;
  int n_chk = 0, n_fail = 0;
  int rd_cycles;
  inst_fetch_unit dut (
    .clk(clk), .rst(rst), .pc(pc), .fetch_req(fetch_req), .flush(flush),
    .busy(busy), .inst(inst), .inst_valid(inst_valid), .fetch_err(fetch_err),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(negedge clk);
  endtask
  initial begin
    repeat (2) step();
    check("rst_mem_rd", mem_rd, 0);
    check("rst_busy", busy, 0);
    check("rst_inst", inst, 0);
    check("rst_valid", inst_valid, 0);
    rst = 1'b0;
    // basic: ack on the third cycle of mem_rd
    pc = 16'h0010; fetch_req = 1'b1;
    step(); fetch_req = 1'b0;
    check("basic_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin
      check("basic_rd", mem_rd, 1);
      check("basic_addr", mem_addr, 16'h0010);
      if (i < 2) step();
    end
    mem_ack = 1'b1; mem_rdata = 16'h1234;
    step(); mem_ack = 1'b0; mem_rdata = 16'h0;
    check("basic_valid", inst_valid, 1);
    check("basic_inst", inst, 16'h1234);
    check("basic_err", fetch_err, 0);
    check("basic_rd_drop", mem_rd, 0);
    step();
    check("basic_valid_once", inst_valid, 0);
    check("basic_hold", inst, 16'h1234);
    check("basic_idle", busy, 0);
    // timeout: never ack
    pc = 16'h0020; fetch_req = 1'b1;
    step(); fetch_req = 1'b0;
    rd_cycles = 0;
    for (int i = 0; i < 40 && mem_rd; i++) begin
      rd_cycles++;
      step();
    end
    check("tmo_cycles", rd_cycles, 15);
    check("tmo_valid", inst_valid, 1);
    check("tmo_err", fetch_err, 1);
    check("tmo_inst", inst, 16'h0000);
    step();
    check("tmo_valid_once", inst_valid, 0);
    check("tmo_err_once", fetch_err, 0);
    // minimum latency fetch after timeout
    pc = 16'h0022; fetch_req = 1'b1;
    step(); fetch_req = 1'b0;
    check("min_addr", mem_addr, 16'h0022);
    mem_ack = 1'b1; mem_rdata = 16'h5A5A;
    step(); mem_ack = 1'b0;
    check("min_valid", inst_valid, 1);
    check("min_inst", inst, 16'h5A5A);
    check("min_err", fetch_err, 0);
    step();
    // flush during REQ: bus completes, data discarded
    pc = 16'h0030; fetch_req = 1'b1;
    step(); fetch_req = 1'b0; flush = 1'b1;
    check("flush_rd", mem_rd, 1);
    step(); flush = 1'b0;
    check("flush_rd_held", mem_rd, 1);
    check("flush_addr_held", mem_addr, 16'h0030);
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    step(); mem_ack = 1'b0;
    check("flush_no_valid", inst_valid, 0);
    check("flush_inst_kept", inst, 16'h5A5A);
    check("flush_rd_drop", mem_rd, 0);
    step();
    check("flush_no_valid2", inst_valid, 0);
    check("flush_idle", busy, 0);
    // fetch while busy is dropped, not queued
    pc = 16'hFFFF; fetch_req = 1'b1;
    step(); pc = 16'h0060;
    check("busy_req", busy, 1);
    check("wrap_addr", mem_addr, 16'hFFFF);
    step(); fetch_req = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h1111;
    step(); mem_ack = 1'b0;
    check("busy_inst", inst, 16'h1111);
    step();
    check("busy_not_queued", mem_rd, 0);
    step();
    check("busy_not_queued2", mem_rd, 0);
    // flush and fetch on the same edge: flush wins
    pc = 16'h0040; fetch_req = 1'b1; flush = 1'b1;
    step(); fetch_req = 1'b0; flush = 1'b0;
    check("flush_wins_rd", mem_rd, 0);
    check("flush_wins_busy", busy, 0);
    // async reset during REQ
    pc = 16'h0070; fetch_req = 1'b1;
    step(); fetch_req = 1'b0;
    check("abort_rd_before", mem_rd, 1);
    #2 rst = 1'b1;
    #1;
    check("abort_rd", mem_rd, 0);
    check("abort_addr", mem_addr, 0);
    check("abort_inst", inst, 0);
    check("abort_busy", busy, 0);
    step(); rst = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h7777;
    step(); mem_ack = 1'b0;
    check("abort_no_valid", inst_valid, 0);
    check("abort_inst_kept", inst, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
